uart_rx_os8: RTL and testbench

//  8x-oversampling UART receiver (8N1, LSB first) with an integrated fractional baud-tick generator.

---
 rtl/uart_rx_os8_pkg.sv | 29 ++
 rtl/uart_rx_os8_baud8_gen.sv | 40 ++++
 rtl/uart_rx_os8.sv | 139 +++++++++++++
 tb/tb_uart_rx_os8.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_os8_pkg.sv
// ============================================================================
//  Module   : uart_rx_os8_pkg
//  Brief    : Shared state encoding and oversampling constants for uart_rx_os8
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_rx_os8_pkg;

    localparam int OS_RATE = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_WAIT_HI = 3'd4
    } uart_state_e;

    // Rounded phase-accumulator step for an OS_RATE*baud tick; 64-bit to avoid overflow.
    function automatic longint calc_inc(input longint clk_hz, input longint baud, input int acc_w);
        longint num;
        num = baud * longint'(OS_RATE) * (longint'(1) << acc_w);
        return (num + clk_hz / 2) / clk_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_os8_baud8_gen.sv
// ============================================================================
//  Module   : baud8_gen
//  Brief    : Fractional phase-accumulator tick generator (carry-out strobe)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module baud8_gen #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned INC   = 2235
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick_o
);

    localparam logic [31:0]    INC_32 = INC;
    localparam logic [ACC_W:0] INC_W  = INC_32[ACC_W:0];

    logic [ACC_W-1:0] acc_q;
    logic             tick_q;
    logic [ACC_W:0]   sum_w;

    assign sum_w = {1'b0, acc_q} + INC_W;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= sum_w[ACC_W-1:0];
            tick_q <= sum_w[ACC_W];
        end
    end

    assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_os8.sv
// ============================================================================
//  Module   : uart_rx_os8
//  Brief    : 8x-oversampling 8N1 UART receiver with built-in baud tick gen
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_os8
    import uart_rx_os8_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27_027_027,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned ACC_W  = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       RxD_ser,
    output logic       Baud8Tick,
    output logic       CTS,
    output logic [7:0] TxD_par,
    output logic       TxD_ready
);

    localparam int unsigned INC      = 32'(calc_inc(longint'(CLK_HZ), longint'(BAUD), int'(ACC_W)));
    localparam logic [2:0]  MID_TICK = 3'(OS_RATE / 2 - 1);
    localparam logic [2:0]  END_TICK = 3'(OS_RATE - 1);

    logic        tick_w;
    logic        rx_w;
    logic [1:0]  sync_q;
    uart_state_e state_q, state_d;
    logic [2:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        cts_q;

    baud8_gen #(
        .ACC_W (ACC_W),
        .INC   (INC)
    ) u_baud8_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick_o  (tick_w)
    );

    assign rx_w = sync_q[1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q     <= 2'b11;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            cts_q      <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], RxD_ser};
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            cts_q      <= (state_q == ST_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        if (tick_w) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_w) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                    end
                end
                ST_START: begin
                    // Confirm the start bit at its centre; a high line here was only a glitch.
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_w ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 3'd1;
                    end
                end
                ST_DATA: begin
                    tick_cnt_d = tick_cnt_q + 3'd1;
                    if (tick_cnt_q == END_TICK) begin
                        shift_d[bit_cnt_q] = rx_w;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    tick_cnt_d = tick_cnt_q + 3'd1;
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                    if (tick_cnt_q == END_TICK) begin
                        if (rx_w) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_HI;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (rx_w) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign Baud8Tick = tick_w;
    assign CTS       = cts_q;
    assign TxD_par   = data_q;
    assign TxD_ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os8.sv
// ============================================================================
//  Module   : tb_uart_rx_os8
//  Brief    : Scoreboard bench for uart_rx_os8 with directed serial frames
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_os8;

    localparam realtime BIT_NS  = 8680.0;
    localparam realtime LAT_MIN = 81000.0;
    localparam realtime LAT_MAX = 84000.0;

    typedef struct {
        logic [7:0] data;
        realtime    t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       baud8_tick;
    logic       cts;
    logic [7:0] txd_par;
    logic       txd_ready;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    uart_rx_os8 dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .RxD_ser   (rxd),
        .Baud8Tick (baud8_tick),
        .CTS       (cts),
        .TxD_par   (txd_par),
        .TxD_ready (txd_ready)
    );

    always #18.5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.data = d;
            e.t0   = $realtime;
            sb_q.push_back(e);
        end
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(BIT_NS);
        end
        rxd = stop_v;
        #(BIT_NS);
    endtask

    // Monitor: every strobe must match the oldest expected frame, within the latency window.
    always @(negedge clk) begin
        if (txd_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: TxD_par=%0h, expected no strobe", txd_par);
            end else begin
                exp_t e;
                realtime lat;
                e   = sb_q.pop_front();
                lat = $realtime - e.t0;
                if (txd_par !== e.data) begin
                    errors++;
                    $display("FAIL rx_data: got %0h, expected %0h", txd_par, e.data);
                end
                checks++;
                if (lat < LAT_MIN || lat > LAT_MAX) begin
                    errors++;
                    $display("FAIL rx_latency: got %0t ns, expected %0t..%0t ns", lat, LAT_MIN, LAT_MAX);
                end
            end
        end
    end

    initial begin
        int tick_cnt;

        // Reset with line idle
        #5000;
        @(negedge clk);
        check("rst_txd_par", 32'(txd_par), 32'h00);
        check("rst_txd_ready", 32'(txd_ready), 32'h0);
        check("rst_cts", 32'(cts), 32'h1);
        rst = 1'b0;

        // Tick rate over 1 ms (27027 cycles of 37 ns)
        tick_cnt = 0;
        repeat (27027) begin
            @(negedge clk);
            if (baud8_tick) tick_cnt++;
        end
        checks++;
        if (tick_cnt < 921 || tick_cnt > 922) begin
            errors++;
            $display("FAIL tick_rate: got %0d ticks, expected 921..922", tick_cnt);
        end
        check("idle_cts", 32'(cts), 32'h1);

        // Frame 0x2A with CTS low mid-frame, then back-to-back 0xAB
        fork
            send_frame(8'h2A, 1'b1, 1'b1);
            begin
                #(BIT_NS * 5);
                @(negedge clk);
                check("frame_cts_low", 32'(cts), 32'h0);
            end
        join
        check("par_2a", 32'(txd_par), 32'h2A);
        send_frame(8'hAB, 1'b1, 1'b1);
        #(BIT_NS * 2);
        check("par_ab", 32'(txd_par), 32'hAB);
        check("cts_after_ab", 32'(cts), 32'h1);

        // 2 us glitch
        rxd = 1'b0;
        #1800;
        check("glitch_cts_low", 32'(cts), 32'h0);
        #200;
        rxd = 1'b1;
        #(BIT_NS);
        check("glitch_cts_back", 32'(cts), 32'h1);
        check("glitch_par_kept", 32'(txd_par), 32'hAB);

        // Framing error: 0x55 with stop 0, line held low a further bit
        send_frame(8'h55, 1'b0, 1'b0);
        #(BIT_NS);
        check("ferr_cts_low", 32'(cts), 32'h0);
        check("ferr_par_kept", 32'(txd_par), 32'hAB);
        rxd = 1'b1;
        #(BIT_NS * 2);
        check("ferr_cts_recover", 32'(cts), 32'h1);
        send_frame(8'h3C, 1'b1, 1'b1);
        #(BIT_NS * 2);
        check("par_3c", 32'(txd_par), 32'h3C);

        // Reset during bit 4 of an aborted 0xF0 frame (bits 4..7 and stop are high)
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b0;
            #(BIT_NS);
        end
        rxd = 1'b1;
        #(BIT_NS / 2);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #(BIT_NS * 5);
        check("abort_par_zero", 32'(txd_par), 32'h00);
        check("abort_cts", 32'(cts), 32'h1);
        send_frame(8'hA5, 1'b1, 1'b1);
        #(BIT_NS * 2);
        check("par_a5", 32'(txd_par), 32'hA5);

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
